// File: rtl/fwd_hazard_ctrl_if.sv
// Decoder-to-controller bundle: ID-stage operand/destination info in,
// stall request, EX-operand mux selects and stall statistics out.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              flush;
    logic              id_stall;
    logic              ex_valid;
    logic [2:0]        fwd_sel_a;
    logic [2:0]        fwd_sel_b;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_regwrite, id_is_load, flush,
        input  id_stall, ex_valid, fwd_sel_a, fwd_sel_b, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_regwrite, id_is_load, flush,
        output id_stall, ex_valid, fwd_sel_a, fwd_sel_b, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding and load-use hazard control. Tracks destination
// tags of in-flight instructions and registers one-hot mux selects for EX.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW           = 5,
    parameter bit          RF_WRITE_THROUGH = 1'b0,
    parameter int unsigned CNT_W            = 16
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_ctrl_if.slave bus
);
    localparam logic [2:0] SEL_RF  = 3'b000;
    localparam logic [2:0] SEL_MEM = 3'b001;
    localparam logic [2:0] SEL_WB  = 3'b010;
    localparam logic [2:0] SEL_RET = 3'b100;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] rd;
    } prod_t;

    // Selects are computed one cycle early from the pre-edge EX/MEM/WB tags, so
    // the RET-stage tag itself is never consulted and is not stored.
    prod_t            ex_tag;
    logic             ex_is_load;
    prod_t            mem_tag;
    prod_t            wb_tag;
    prod_t            id_tag;
    logic [2:0]       sel_a;
    logic [2:0]       sel_b;
    logic [2:0]       sel_a_next;
    logic [2:0]       sel_b_next;
    logic             hazard;
    logic             stall;
    logic [CNT_W-1:0] count;

    function automatic logic producer_hit(input prod_t p, input logic [REG_AW-1:0] r);
        return p.valid && p.regwrite && (p.rd == r) && (r != '0);
    endfunction

    function automatic logic [2:0] select_for(
        input logic [REG_AW-1:0] r,
        input prod_t             ex,
        input prod_t             mem,
        input prod_t             wb
    );
        logic [2:0] sel;
        sel = SEL_RF;
        if (producer_hit(ex, r)) begin
            sel = SEL_MEM;
        end else if (producer_hit(mem, r)) begin
            sel = SEL_WB;
        end else if (!RF_WRITE_THROUGH && producer_hit(wb, r)) begin
            sel = SEL_RET;
        end
        return sel;
    endfunction

    always_comb begin
        id_tag     = '{valid: bus.id_valid, regwrite: bus.id_regwrite, rd: bus.id_rd};
        hazard     = bus.id_valid && ex_is_load &&
                     (producer_hit(ex_tag, bus.id_rs) || producer_hit(ex_tag, bus.id_rt));
        stall      = hazard && !bus.flush;
        sel_a_next = SEL_RF;
        sel_b_next = SEL_RF;
        if (!bus.flush && !stall && bus.id_valid) begin
            sel_a_next = select_for(bus.id_rs, ex_tag, mem_tag, wb_tag);
            sel_b_next = select_for(bus.id_rt, ex_tag, mem_tag, wb_tag);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag     <= '0;
            ex_is_load <= 1'b0;
            mem_tag    <= '0;
            wb_tag     <= '0;
            sel_a      <= SEL_RF;
            sel_b      <= SEL_RF;
            count      <= '0;
        end else begin
            mem_tag <= ex_tag;
            wb_tag  <= mem_tag;
            if (bus.flush || stall) begin
                ex_tag     <= '0;
                ex_is_load <= 1'b0;
            end else begin
                ex_tag     <= id_tag;
                ex_is_load <= bus.id_is_load;
            end
            sel_a <= sel_a_next;
            sel_b <= sel_b_next;
            if (stall && count != '1) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(sel_a) && $onehot0(sel_b));

    assign bus.id_stall    = stall;
    assign bus.ex_valid    = ex_tag.valid;
    assign bus.fwd_sel_a   = sel_a;
    assign bus.fwd_sel_b   = sel_b;
    assign bus.stall_count = count;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: a default instance and a write-through instance with a
// narrow stall counter are driven with the same instruction stream.
module tb_fwd_hazard_ctrl;
    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       fl;
    } instr_t;

    typedef struct packed {
        logic        v;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [2:0]  wa;
        logic [2:0]  wb;
        logic [15:0] cm;
        logic [2:0]  cw;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] cnt_m = '0;
    logic [2:0]  cnt_w = '0;

    fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) m_if ();
    fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(3))  w_if ();

    fwd_hazard_ctrl #(.REG_AW(5), .RF_WRITE_THROUGH(1'b0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(m_if.slave)
    );
    fwd_hazard_ctrl #(.REG_AW(5), .RF_WRITE_THROUGH(1'b1), .CNT_W(3)) dut_wt (
        .clk(clk), .rst(rst), .bus(w_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic rw, input logic ld,
                                  input logic fl);
        return '{v: v, rs: rs, rt: rt, rd: rd, rw: rw, ld: ld, fl: fl};
    endfunction

    task automatic present(input instr_t ins);
        m_if.id_valid = ins.v;  w_if.id_valid = ins.v;
        m_if.id_rs = ins.rs;    w_if.id_rs = ins.rs;
        m_if.id_rt = ins.rt;    w_if.id_rt = ins.rt;
        m_if.id_rd = ins.rd;    w_if.id_rd = ins.rd;
        m_if.id_regwrite = ins.rw;  w_if.id_regwrite = ins.rw;
        m_if.id_is_load = ins.ld;   w_if.id_is_load = ins.ld;
        m_if.flush = ins.fl;    w_if.flush = ins.fl;
    endtask

    task automatic step(input instr_t ins, input logic st, input logic v,
                        input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] wa, input logic [2:0] wb);
        @(negedge clk);
        present(ins);
        #1;
        check("id_stall", m_if.id_stall, st);
        check("id_stall_wt", w_if.id_stall, st);
        if (st) begin
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            if (cnt_w != 3'd7) cnt_w = cnt_w + 3'd1;
        end
        sb.push_back('{v: v, a: a, b: b, wa: wa, wb: wb, cm: cnt_m, cw: cnt_w});
    endtask

    task automatic rst_step(input instr_t ins, input logic st);
        @(negedge clk);
        present(ins);
        #1;
        check("id_stall_pre_rst", m_if.id_stall, st);
        rst = 1'b1;
        cnt_m = '0;
        cnt_w = '0;
        sb.push_back('0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (3) step(mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("ex_valid", m_if.ex_valid, mon_e.v);
            check("fwd_sel_a", m_if.fwd_sel_a, mon_e.a);
            check("fwd_sel_b", m_if.fwd_sel_b, mon_e.b);
            check("stall_count", m_if.stall_count, mon_e.cm);
            check("ex_valid_wt", w_if.ex_valid, mon_e.v);
            check("fwd_sel_a_wt", w_if.fwd_sel_a, mon_e.wa);
            check("fwd_sel_b_wt", w_if.fwd_sel_b, mon_e.wb);
            check("stall_count_wt", w_if.stall_count, mon_e.cw);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        instr_t nop, add3, lw7;
        nop  = mk(0, 0, 0, 0, 0, 0, 0);
        add3 = mk(1, 1, 2, 3, 1, 0, 0);
        lw7  = mk(1, 1, 0, 7, 1, 1, 0);

        // Load presented during reset must not leave a valid EX tag behind.
        present(lw7);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_valid", m_if.ex_valid, 1'b0);
        check("rst_sel_a", m_if.fwd_sel_a, 3'b000);
        check("rst_sel_b", m_if.fwd_sel_b, 3'b000);
        check("rst_count", m_if.stall_count, 16'd0);
        rst = 1'b0;
        step(mk(1, 7, 7, 8, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        drain();

        // Forwarding distance 1..4
        step(add3, 0, 1, 0, 0, 0, 0);
        step(mk(1, 3, 4, 6, 1, 0, 0), 0, 1, 3'b001, 0, 3'b001, 0);
        drain();
        step(add3, 0, 1, 0, 0, 0, 0);
        step(nop, 0, 0, 0, 0, 0, 0);
        step(mk(1, 3, 4, 6, 1, 0, 0), 0, 1, 3'b010, 0, 3'b010, 0);
        drain();
        step(add3, 0, 1, 0, 0, 0, 0);
        step(nop, 0, 0, 0, 0, 0, 0);
        step(nop, 0, 0, 0, 0, 0, 0);
        step(mk(1, 3, 4, 6, 1, 0, 0), 0, 1, 3'b100, 0, 3'b000, 0);
        drain();
        step(add3, 0, 1, 0, 0, 0, 0);
        repeat (3) step(nop, 0, 0, 0, 0, 0, 0);
        step(mk(1, 3, 4, 6, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        drain();

        // Nearest producer wins; selects are independent per operand
        step(mk(1, 1, 2, 5, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        step(mk(1, 1, 2, 5, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        step(mk(1, 1, 5, 9, 1, 0, 0), 0, 1, 0, 3'b001, 0, 3'b001);
        step(mk(1, 9, 5, 10, 1, 0, 0), 0, 1, 3'b001, 3'b010, 3'b001, 3'b010);
        drain();
        step(mk(1, 1, 2, 5, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        step(mk(1, 1, 2, 5, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        step(nop, 0, 0, 0, 0, 0, 0);
        step(mk(1, 1, 5, 9, 1, 0, 0), 0, 1, 0, 3'b010, 0, 3'b010);
        drain();

        // r0 writer and non-writing producer never forward
        step(mk(1, 1, 2, 0, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        step(mk(1, 0, 0, 11, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        drain();
        step(mk(1, 1, 2, 3, 0, 0, 0), 0, 1, 0, 0, 0, 0);
        step(mk(1, 3, 3, 12, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        drain();

        // Load-use on rt, then on rs
        step(lw7, 0, 1, 0, 0, 0, 0);
        step(mk(1, 2, 7, 8, 1, 0, 0), 1, 0, 0, 0, 0, 0);
        step(mk(1, 2, 7, 8, 1, 0, 0), 0, 1, 0, 3'b010, 0, 3'b010);
        drain();
        step(lw7, 0, 1, 0, 0, 0, 0);
        step(mk(1, 7, 0, 8, 1, 0, 0), 1, 0, 0, 0, 0, 0);
        step(mk(1, 7, 0, 8, 1, 0, 0), 0, 1, 3'b010, 0, 3'b010, 0);
        drain();

        // Load two ahead, invalid consumer, load to r0: no stall
        step(lw7, 0, 1, 0, 0, 0, 0);
        step(nop, 0, 0, 0, 0, 0, 0);
        step(mk(1, 2, 7, 8, 1, 0, 0), 0, 1, 0, 3'b010, 0, 3'b010);
        drain();
        step(lw7, 0, 1, 0, 0, 0, 0);
        step(mk(0, 7, 7, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
        drain();
        step(mk(1, 1, 0, 0, 1, 1, 0), 0, 1, 0, 0, 0, 0);
        step(mk(1, 0, 0, 8, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        drain();

        // Flush beats hazard; flushed writer does not forward
        step(lw7, 0, 1, 0, 0, 0, 0);
        step(mk(1, 2, 7, 8, 1, 0, 1), 0, 0, 0, 0, 0, 0);
        step(nop, 0, 0, 0, 0, 0, 0);
        drain();
        step(mk(1, 1, 2, 3, 1, 0, 1), 0, 0, 0, 0, 0, 0);
        step(mk(1, 3, 0, 12, 1, 0, 0), 0, 1, 0, 0, 0, 0);
        drain();

        // Reset in the stall cycle, then replay
        step(lw7, 0, 1, 0, 0, 0, 0);
        rst_step(mk(1, 2, 7, 8, 1, 0, 0), 1);
        step(lw7, 0, 1, 0, 0, 0, 0);
        step(mk(1, 2, 7, 8, 1, 0, 0), 1, 0, 0, 0, 0, 0);
        step(mk(1, 2, 7, 8, 1, 0, 0), 0, 1, 0, 3'b010, 0, 3'b010);

        // Drive the 3-bit counter past all-ones
        for (int i = 0; i < 8; i++) begin
            step(lw7, 0, 1, 0, 0, 0, 0);
            step(mk(1, 2, 7, 8, 1, 0, 0), 1, 0, 0, 0, 0, 0);
            step(mk(1, 2, 7, 8, 1, 0, 0), 0, 1, 0, 3'b010, 0, 3'b010);
        end
        drain();

        repeat (2) @(posedge clk);
        #2;
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
